freq_scan: RTL and testbench
============================

// Module: freq_scan
// PURPOSE
//  Time-multiplexes one quarter-turn frequency counter across NCH phase channels.
//  Visits enabled channels round-robin. Each visit is a 1-strobe settle plus a
//  2^WIN_LEN-strobe measurement window. Stores per-channel freq/errs results.
//  Serves results over a one-cycle request/response readout port to host regs.
// PARAMETERS
//  NCH      4   number of phase channels (2..16)
//  WIN_LEN  17  log2 of measurement window length, in strobes
//  CW       $clog2(NCH)  channel index width (derived; do not override)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  strobe     in   1       sample-enable; all phase processing is qualified by it
//  phase_bus  in   2*NCH   quarter-turn phase; channel k at [2k+1:2k]
//  run        in   1       1 = scan enabled
//  chan_mask  in   NCH     per-channel enable; sampled at each channel advance
//  cur_chan   out  CW      channel currently being settled or measured
//  scan_done  out  1       1-clk pulse when the last enabled channel of a pass stores
//  rd_req     in   1       readout request
//  rd_addr    in   CW      readout channel
//  rd_valid   out  1       high 1 clk after rd_req
//  rd_freq    out  16      signed result; LSB = 2 quarter-turns per window
//  rd_errs    out  16      count of half-turn jumps in window, saturating
//  rd_fresh   out  1       result stored since this channel's previous read
// BEHAVIOUR
//  - Reset: FSM=IDLE, cur_chan=0, all result regs/fresh/acc=0, all outputs 0.
//  - FSM states:
//     IDLE: leave when run=1 and mask!=0. Go to SETTLE on lowest enabled channel.
//     SETTLE: on first strobe, capture old_phase; clear acc and err; go to MEASURE.
//     MEASURE: on each strobe, diff = phase - old_phase (2-bit wrap); old_phase <= phase.
//        diff=2'b10 -> err+1, acc unchanged; else acc += $signed(diff).
//        After 2^WIN_LEN counted strobes, go to STORE.
//     STORE (1 clk, strobe-independent): write result[cur_chan]; set fresh[cur_chan].
//        Advance to next enabled channel above cur_chan, wrapping to 0; go to SETTLE.
//        Wrap-around, or a single enabled channel, pulses scan_done.
//        If mask is now 0, go to IDLE.
//  - acc: signed WIN_LEN+2 bits. freq = acc>>>1, saturated to int16.
//  - err: WIN_LEN+1 bits. errs saturates at 16'hFFFF.
//  - run=0 in any state -> IDLE next clk. Partial window is discarded; stored results kept.
//  - Mask bit cleared mid-window: current window completes and stores. Skipped thereafter.
//  - Readout: registered. rd_* updates 1 clk after rd_req; fresh[rd_addr] clears.
//    - Store and read of the same channel on one clk:
//      rd returns the pre-store value with rd_fresh=old flag; fresh ends 1.
//    - rd_req=0: rd_valid=0; other rd_* outputs hold.
//  - Async reset mid-window: immediate return to reset values; no partial store.
// STRUCTURE
//  - Shared package freq_pkg:
//     FSM state enum {IDLE, SETTLE, MEASURE, STORE}
//     PHASE_ERR = 2'b10
//     function sat16(signed) for freq/err saturation
//  - One sub-module freq_accum: old_phase/diff/acc/err datapath.
//    Ports: clear, enable (strobe & MEASURE), load_old.
//    Outputs: freq16, errs16.
//  - Top holds FSM, window counter, channel mux, result regfile, readout.
// TESTING (WIN_LEN=4 -> 16-strobe window, NCH=4, strobe every 3rd clk)
//  1 ch0 phase +1 per strobe, mask=4'b0001
//    -> rd ch0: freq=8, errs=0; scan_done each pass
//  2 ch1 phase -1 per strobe, mask=4'b0010
//    -> freq=-8 (16'hFFF8), errs=0
//  3 ch2 phase +2 per strobe
//    -> freq=0, errs=16
//  4 mask=4'b0101
//    -> cur_chan sequence 0,2,0,2; ch1/ch3 results stay 0; fresh only on 0,2
//  5 run dropped at strobe 8 of ch0 window, raised later
//    -> prior ch0 result unchanged; next pass stores a full-window value
//  6 read ch0 twice with no store between
//    -> rd_fresh=1 then 0
//  7 read ch0 on its STORE clk
//    -> old value returned, fresh=1 afterward
//  8 rst_n pulse mid-MEASURE
//    -> all outputs 0, FSM IDLE within 0 clks

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types, constants and saturation helper for the frequency scanner.
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    STORE   = 2'd3
  } state_e;

  // A two-quadrant phase step is ambiguous in direction, so it is counted as an error.
  localparam logic [1:0] PHASE_ERR = 2'b10;

  function automatic logic [15:0] sat16(input logic signed [31:0] v, input logic is_unsigned);
    logic [15:0] r;
    r = v[15:0];
    if (is_unsigned) begin
      if (v > 32'sd65535) begin
        r = 16'hFFFF;
      end else if (v < 32'sd0) begin
        r = 16'h0000;
      end else begin
        r = v[15:0];
      end
    end else begin
      if (v > 32'sd32767) begin
        r = 16'h7FFF;
      end else if (v < -32'sd32768) begin
        r = 16'h8000;
      end else begin
        r = v[15:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_scan_if.sv
// Host readout port: one-cycle request, registered response.
interface freq_scan_if #(
  parameter int CW = 2
);
  logic          rd_req;
  logic [CW-1:0] rd_addr;
  logic          rd_valid;
  logic [15:0]   rd_freq;
  logic [15:0]   rd_errs;
  logic          rd_fresh;

  modport master (output rd_req, rd_addr, input rd_valid, rd_freq, rd_errs, rd_fresh);
  modport slave  (input rd_req, rd_addr, output rd_valid, rd_freq, rd_errs, rd_fresh);
endinterface

// File: rtl/freq_accum.sv
// Quarter-turn phase differencing datapath: accumulates signed steps over one
// window and counts ambiguous half-turn jumps separately.
module freq_accum
  import freq_pkg::*;
#(
  parameter int WIN_LEN = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  phase,
  input  logic        clear,
  input  logic        enable,
  input  logic        load_old,
  output logic [15:0] freq16,
  output logic [15:0] errs16
);

  localparam int AW = WIN_LEN + 2;
  localparam int EW = WIN_LEN + 1;

  logic [1:0]           old_phase_r;
  logic signed [AW-1:0] acc_r;
  logic [EW-1:0]        err_r;
  logic [1:0]           diff_s;
  logic signed [AW-1:0] acc_half_s;

  assign diff_s     = phase - old_phase_r;
  assign acc_half_s = acc_r >>> 1;
  assign freq16     = sat16(32'(acc_half_s), 1'b0);
  assign errs16     = sat16(32'(err_r), 1'b1);

  // Previous-phase register and window accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      old_phase_r <= 2'b00;
      acc_r       <= '0;
      err_r       <= '0;
    end else begin
      if (load_old || enable) begin
        old_phase_r <= phase;
      end else begin
        old_phase_r <= old_phase_r;
      end
      if (clear) begin
        acc_r <= '0;
        err_r <= '0;
      end else if (enable && (diff_s == PHASE_ERR)) begin
        err_r <= err_r + EW'(1);
      end else if (enable) begin
        acc_r <= acc_r + AW'($signed(diff_s));
      end else begin
        acc_r <= acc_r;
        err_r <= err_r;
      end
    end
  end

endmodule

// File: rtl/freq_scan.sv
// Round-robin scanner sharing one quarter-turn frequency counter across NCH
// phase channels, with a per-channel result file and a registered readout port.
module freq_scan
  import freq_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIN_LEN = 17,
  parameter int CW      = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic [2*NCH-1:0] phase_bus,
  input  logic             run,
  input  logic [NCH-1:0]   chan_mask,
  output logic [CW-1:0]    cur_chan,
  output logic             scan_done,
  freq_scan_if.slave       rd
);

  state_e               state_r, state_nxt_s;
  logic [CW-1:0]        cur_chan_r, chan_nxt_s, low_chan_s, up_chan_s;
  logic                 up_found_s, any_en_s;
  logic [WIN_LEN-1:0]   win_cnt_r;
  logic                 win_last_s;
  logic [1:0]           phase_s;
  logic                 settle_en_s, meas_en_s, store_s, done_s;
  logic                 scan_done_r;
  logic [15:0]          acc_freq_s, acc_errs_s;
  logic [15:0]          freq_mem_r [NCH];
  logic [15:0]          errs_mem_r [NCH];
  logic [NCH-1:0]       fresh_r;
  logic [15:0]          rd_freq_s, rd_errs_s;
  logic                 rd_fresh_s;
  logic                 rd_valid_r, rd_fresh_r;
  logic [15:0]          rd_freq_r, rd_errs_r;

  assign any_en_s   = |chan_mask;
  assign win_last_s = &win_cnt_r;
  assign cur_chan   = cur_chan_r;
  assign scan_done  = scan_done_r;

  // Select the phase pair of the channel under measurement.
  always_comb begin
    phase_s = 2'b00;
    for (int k = 0; k < NCH; k++) begin
      if (cur_chan_r == CW'(k)) begin
        phase_s = phase_bus[2*k +: 2];
      end else begin
        phase_s = phase_s;
      end
    end
  end

  // Lowest enabled channel, and lowest enabled channel above the current one.
  always_comb begin
    low_chan_s = '0;
    up_chan_s  = '0;
    up_found_s = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (chan_mask[k]) begin
        low_chan_s = CW'(k);
        if (k > int'(cur_chan_r)) begin
          up_chan_s  = CW'(k);
          up_found_s = 1'b1;
        end else begin
          up_found_s = up_found_s;
        end
      end else begin
        low_chan_s = low_chan_s;
      end
    end
  end

  // Scan FSM next-state and control decode; dropping run abandons any window.
  always_comb begin
    state_nxt_s = state_r;
    chan_nxt_s  = cur_chan_r;
    settle_en_s = 1'b0;
    meas_en_s   = 1'b0;
    store_s     = 1'b0;
    done_s      = 1'b0;
    if (!run) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_en_s) begin
            state_nxt_s = SETTLE;
            chan_nxt_s  = low_chan_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SETTLE: begin
          if (strobe) begin
            settle_en_s = 1'b1;
            state_nxt_s = MEASURE;
          end else begin
            state_nxt_s = SETTLE;
          end
        end
        MEASURE: begin
          if (strobe) begin
            meas_en_s = 1'b1;
            if (win_last_s) begin
              state_nxt_s = STORE;
            end else begin
              state_nxt_s = MEASURE;
            end
          end else begin
            state_nxt_s = MEASURE;
          end
        end
        STORE: begin
          store_s = 1'b1;
          if (!any_en_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SETTLE;
            chan_nxt_s  = up_found_s ? up_chan_s : low_chan_s;
            done_s      = !up_found_s;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // FSM state, current channel, window counter and pass-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cur_chan_r  <= '0;
      win_cnt_r   <= '0;
      scan_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cur_chan_r  <= chan_nxt_s;
      scan_done_r <= done_s;
      if (settle_en_s) begin
        win_cnt_r <= '0;
      end else if (meas_en_s) begin
        win_cnt_r <= win_cnt_r + WIN_LEN'(1);
      end else begin
        win_cnt_r <= win_cnt_r;
      end
    end
  end

  freq_accum #(.WIN_LEN(WIN_LEN)) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase    (phase_s),
    .clear    (settle_en_s),
    .enable   (meas_en_s),
    .load_old (settle_en_s),
    .freq16   (acc_freq_s),
    .errs16   (acc_errs_s)
  );

  // Result file; a store sets fresh and wins over a same-cycle read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        freq_mem_r[k] <= 16'h0000;
        errs_mem_r[k] <= 16'h0000;
      end
      fresh_r <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (store_s && (cur_chan_r == CW'(k))) begin
          freq_mem_r[k] <= acc_freq_s;
          errs_mem_r[k] <= acc_errs_s;
          fresh_r[k]    <= 1'b1;
        end else if (rd.rd_req && (rd.rd_addr == CW'(k))) begin
          fresh_r[k] <= 1'b0;
        end else begin
          fresh_r[k] <= fresh_r[k];
        end
      end
    end
  end

  // Readout mux; addresses beyond NCH read as zero.
  always_comb begin
    rd_freq_s  = 16'h0000;
    rd_errs_s  = 16'h0000;
    rd_fresh_s = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (rd.rd_addr == CW'(k)) begin
        rd_freq_s  = freq_mem_r[k];
        rd_errs_s  = errs_mem_r[k];
        rd_fresh_s = fresh_r[k];
      end else begin
        rd_fresh_s = rd_fresh_s;
      end
    end
  end

  // Registered readout response; data holds between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_freq_r  <= 16'h0000;
      rd_errs_r  <= 16'h0000;
      rd_fresh_r <= 1'b0;
    end else begin
      rd_valid_r <= rd.rd_req;
      if (rd.rd_req) begin
        rd_freq_r  <= rd_freq_s;
        rd_errs_r  <= rd_errs_s;
        rd_fresh_r <= rd_fresh_s;
      end else begin
        rd_freq_r  <= rd_freq_r;
        rd_errs_r  <= rd_errs_r;
        rd_fresh_r <= rd_fresh_r;
      end
    end
  end

  assign rd.rd_valid = rd_valid_r;
  assign rd.rd_freq  = rd_freq_r;
  assign rd.rd_errs  = rd_errs_r;
  assign rd.rd_fresh = rd_fresh_r;

endmodule

// File: tb/tb_freq_scan.sv
// Directed bench for freq_scan: 16-strobe windows, strobe every third clock,
// per-channel constant phase steps.
module tb_freq_scan;

  logic       clk;
  logic       rst_n;
  logic       strobe;
  logic [7:0] phase_bus;
  logic       run;
  logic [3:0] chan_mask;
  logic [1:0] cur_chan;
  logic       scan_done;
  logic [1:0] step [4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  freq_scan_if #(.CW(2)) rd_if ();

  freq_scan #(.NCH(4), .WIN_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe    (strobe),
    .phase_bus (phase_bus),
    .run       (run),
    .chan_mask (chan_mask),
    .cur_chan  (cur_chan),
    .scan_done (scan_done),
    .rd        (rd_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe every third clock; each channel's phase advances by its step after each strobe.
  initial begin
    int scnt;
    scnt      = 0;
    strobe    = 1'b0;
    phase_bus = 8'h00;
    forever begin
      @(negedge clk);
      if (strobe) begin
        for (int k = 0; k < 4; k++) begin
          phase_bus[2*k +: 2] = phase_bus[2*k +: 2] + step[k];
        end
      end
      scnt   = (scnt == 2) ? 0 : scnt + 1;
      strobe = (scnt == 0);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (scan_done === 1'b1) seen = 1'b1;
    end
    chk(tag, {15'd0, seen}, 16'd1);
  endtask

  task automatic wait_chan(input string tag, input logic [1:0] exp, input int max_cyc);
    logic [1:0] start;
    start = cur_chan;
    for (int i = 0; i < max_cyc && cur_chan === start; i++) begin
      @(negedge clk);
    end
    chk(tag, {14'd0, cur_chan}, {14'd0, exp});
  endtask

  // Issue a read at the current negedge and check the response one clock later.
  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] ef,
                        input logic [15:0] ee, input logic efr);
    rd_if.rd_req  = 1'b1;
    rd_if.rd_addr = a;
    @(negedge clk);
    chk({tag, ".valid"}, {15'd0, rd_if.rd_valid}, 16'd1);
    chk({tag, ".freq"}, rd_if.rd_freq, ef);
    chk({tag, ".errs"}, rd_if.rd_errs, ee);
    chk({tag, ".fresh"}, {15'd0, rd_if.rd_fresh}, {15'd0, efr});
    rd_if.rd_req = 1'b0;
  endtask

  initial begin
    step[0] = 2'd1;
    step[1] = 2'd3;
    step[2] = 2'd2;
    step[3] = 2'd0;
    rst_n = 1'b0;
    run = 1'b0;
    chan_mask = 4'b0000;
    rd_if.rd_req = 1'b0;
    rd_if.rd_addr = 2'd0;

    repeat (3) @(negedge clk);
    chk("rst.cur_chan", {14'd0, cur_chan}, 16'd0);
    chk("rst.scan_done", {15'd0, scan_done}, 16'd0);
    chk("rst.rd_valid", {15'd0, rd_if.rd_valid}, 16'd0);
    chk("rst.rd_freq", rd_if.rd_freq, 16'd0);
    chk("rst.rd_errs", rd_if.rd_errs, 16'd0);
    chk("rst.rd_fresh", {15'd0, rd_if.rd_fresh}, 16'd0);
    rst_n = 1'b1;

    // ch0 +1 per strobe, single channel: pulse every pass, freq 8
    run = 1'b1;
    chan_mask = 4'b0001;
    wait_done("t1.done_a", 200);
    wait_done("t1.done_b", 200);
    rd_chk("t1.rd0", 2'd0, 16'd8, 16'd0, 1'b1);
    rd_chk("t6.rd0_again", 2'd0, 16'd8, 16'd0, 1'b0);
    @(negedge clk);
    chk("t6.valid_low", {15'd0, rd_if.rd_valid}, 16'd0);
    chk("t6.freq_hold", rd_if.rd_freq, 16'd8);

    // ch1 -1 per strobe
    chan_mask = 4'b0010;
    wait_done("t2.done", 300);
    chk("t2.cur_chan", {14'd0, cur_chan}, 16'd1);
    rd_chk("t2.rd1", 2'd1, 16'hFFF8, 16'd0, 1'b1);

    // ch2 +2 per strobe: every step is a half-turn jump
    chan_mask = 4'b0100;
    wait_done("t3.done", 300);
    rd_chk("t3.rd2", 2'd2, 16'd0, 16'd16, 1'b1);
    rd_chk("t3.rd1", 2'd1, 16'hFFF8, 16'd0, 1'b1);

    // mask 0101: channels 0 and 2 alternate
    chan_mask = 4'b0101;
    wait_done("t4.done_a", 200);
    chk("t4.seq0", {14'd0, cur_chan}, 16'd0);
    wait_chan("t4.seq1", 2'd2, 200);
    rd_chk("t4.rd0", 2'd0, 16'd8, 16'd0, 1'b1);
    rd_chk("t4.rd1", 2'd1, 16'hFFF8, 16'd0, 1'b0);
    rd_chk("t4.rd3", 2'd3, 16'd0, 16'd0, 1'b0);
    wait_done("t4.done_b", 200);
    chk("t4.seq2", {14'd0, cur_chan}, 16'd0);
    wait_chan("t4.seq3", 2'd2, 200);
    rd_chk("t4.rd2", 2'd2, 16'd0, 16'd16, 1'b1);

    // run dropped mid-window on ch0, then restarted with a -1 step
    chan_mask = 4'b0001;
    wait_done("t5.done_a", 200);
    step[0] = 2'd3;
    repeat (26) @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rd_chk("t5.rd0_a", 2'd0, 16'd8, 16'd0, 1'b1);
    rd_chk("t5.rd0_b", 2'd0, 16'd8, 16'd0, 1'b0);
    repeat (80) @(negedge clk);
    rd_chk("t5.rd0_idle", 2'd0, 16'd8, 16'd0, 1'b0);
    chk("t5.cur_chan", {14'd0, cur_chan}, 16'd0);
    run = 1'b1;
    wait_done("t5.done_b", 200);

    // read ch0 exactly on its next STORE clock (51 clocks per single-channel pass)
    step[0] = 2'd1;
    rd_chk("t5.rd0_full", 2'd0, 16'hFFF8, 16'd0, 1'b1);
    repeat (49) @(negedge clk);
    rd_chk("t7.rd_on_store", 2'd0, 16'hFFF8, 16'd0, 1'b0);
    chk("t7.store_aligned", {15'd0, scan_done}, 16'd1);
    rd_chk("t7.rd_after", 2'd0, 16'd8, 16'd0, 1'b1);

    // async reset mid-MEASURE on ch2
    chan_mask = 4'b0101;
    wait_chan("t8.on_ch2", 2'd2, 200);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t8.cur_chan", {14'd0, cur_chan}, 16'd0);
    chk("t8.scan_done", {15'd0, scan_done}, 16'd0);
    chk("t8.rd_valid", {15'd0, rd_if.rd_valid}, 16'd0);
    chk("t8.rd_freq", rd_if.rd_freq, 16'd0);
    chk("t8.rd_errs", rd_if.rd_errs, 16'd0);
    chk("t8.rd_fresh", {15'd0, rd_if.rd_fresh}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("t8.rd2", 2'd2, 16'd0, 16'd0, 1'b0);
    rd_chk("t8.rd0", 2'd0, 16'd0, 16'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
